stream_rr_mux: RTL
==================

Name: stream_rr_mux

Overview:
- N-to-1 packet-aware stream multiplexer; the gathering counterpart of the 1-to-N demultiplexer.
- Collects M-bit beats from N valid/ready source channels and forwards them on one registered output channel.
- Channels are granted round-robin, and a grant is held until the packet's last beat is accepted.
- Sits upstream of shared sinks (one bus, one FIFO) that are fed by several producers.

Parameters:
- N, 4, number of input channels; legal range N >= 2, N need not be a power of 2.
- M, 8, data bits per beat.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  M x [N]  per-channel beat data; unpacked array in_data[N].
- in_valid  input  [N]  per-channel beat valid.
- in_last  input  [N]  marks the final beat of a packet on that channel.
- in_ready  output  [N]  per-channel accept.
- out_data  output  M  registered beat data.
- out_valid  output  1  registered beat valid.
- out_last  output  1  registered last flag.
- out_sel  output  $clog2(N)  index of the channel that supplied the current out beat.
- out_ready  input  1  downstream accept.

Behaviour:
- Transfer rule: a transfer happens on any edge where valid && ready.
  - Sources must hold data and last stable while valid && !ready.
  - The block does the same on its output.
- load_en = !out_valid || out_ready.
  - The output register loads only when load_en is 1.
  - This gives full throughput: one beat per cycle, 1-cycle latency from input to output.
- State machine (arb_state_e):
  - IDLE: no packet is in progress.
    - When load_en is 1, grant g = first channel with in_valid set, searching from ptr upward with wrap N-1 -> 0.
    - in_ready[g] = 1; every other in_ready = 0; the beat loads into the output register.
    - If the beat has in_last = 0: go to LOCKED, holding lock_idx = g.
    - If in_last = 1: stay in IDLE and set ptr = (g+1) mod N.
    - If no channel is valid, or load_en is 0: every in_ready = 0, state and ptr unchanged.
  - LOCKED: in_ready[lock_idx] = load_en; every other in_ready = 0, even if that channel is valid.
    - When a beat from lock_idx with in_last = 1 is accepted: go to IDLE and set ptr = (lock_idx+1) mod N.
    - A lock_idx bubble (in_valid = 0) stalls the output. No other channel is granted mid-packet.
- Combinational paths:
  - in_ready is combinational from state, ptr, in_valid and out_ready.
  - in_valid never depends on in_ready; no combinational path exists from in_ready back to in_valid.
- Output register on load:
  - out_data, out_last and out_sel take the granted channel's values.
  - out_valid = 1 if a beat was accepted, else 0 when out_ready drained the register.
  - Held unchanged while out_valid && !out_ready.
- Reset (rst_n low, asynchronous):
  - out_valid = 0, out_data = 0, out_last = 0, out_sel = 0, ptr = 0, lock_idx = 0, state = IDLE.
  - in_ready forced to all 0 while rst_n is low.
  - Reset asserted mid-packet drops the lock and any held beat. Upstream must resend.
- Fairness bound: a continuously valid channel is granted within N-1 packet completions by other channels.
- Boundaries:
  - ptr wraps at N-1 for non-power-of-2 N; index values >= N are never produced.
  - A single-beat packet (last on the first beat) never enters LOCKED.
  - Back-to-back packets from the same channel are granted consecutively only if no other channel is valid.

Decomposition:
- Package stream_mux_pkg holds:
  - typedef enum logic {IDLE, LOCKED} arb_state_e.
  - function rr_next(ptr, N) for the wrap computation.
- Sub-module rr_arbiter, purely combinational:
  - Inputs: req[N] and ptr.
  - Outputs: grant index and any_req.
  - Instantiated once in stream_rr_mux.
- State, ptr, lock_idx and the output register stay in the top module.

Test Plan (N=4, M=8):
- Reset, all in_valid = 0 -> out_valid = 0, in_ready = 4'b0000, out_sel = 0. Assert rst_n mid-stream -> out_valid drops to 0 asynchronously.
- Ch0..3 all valid, single-beat packets, data 0x10..0x13, out_ready = 1:
  - Output order 0x10, 0x11, 0x12, 0x13, 0x10…, one beat per cycle.
  - out_sel = 0, 1, 2, 3, 0.
- Ch1 sends 3 beats (0xA0, 0xA1, 0xA2 with last) while ch2 stays valid (0xB0, last):
  - Output 0xA0, 0xA1, 0xA2, 0xB0.
  - in_ready[2] = 0 until 0xA2 is accepted.
- Ch3 beat 0x55 valid, out_ready held 0 for 3 cycles:
  - out_data = 0x55 and out_valid = 1 stay stable.
  - in_ready = 0000 after the first load.
  - Transfer completes on the cycle out_ready = 1.
- LOCKED on ch0 with ch0 in_valid low for 2 cycles and ch1 valid:
  - No ch1 beat appears; out_valid = 0 during the gap.
  - ch0 resumes, and ch1 is granted after ch0's last beat.
- Only ch2 valid, 3 back-to-back single-beat packets (0x01, 0x02, 0x03) -> output 0x01, 0x02, 0x03 on consecutive cycles.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin packet stream multiplexer.
package stream_mux_pkg;

    typedef enum logic {IDLE, LOCKED} arb_state_e;

    // Next channel index after ptr, wrapping at n-1 so non-power-of-2 counts never overflow.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping N-1 -> 0.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          any_req
);

    int idx;

    // NOTE: every output gets a default before the search loop so no latch is inferred.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = int'(ptr);
        for (int i = 0; i < N; i++) begin
            if (!any_req && req[IW'(idx)]) begin
                any_req = 1'b1;
                grant   = IW'(idx);
            end
            idx = rr_next(idx, N);
        end
    end

endmodule

// File: rtl/stream_rr_mux.sv
// N-to-1 packet-aware stream mux: round-robin grant held until the packet's last beat, registered output.
module stream_rr_mux
    import stream_mux_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 8,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [M-1:0]  in_data [N],
    input  logic [N-1:0]  in_valid,
    input  logic [N-1:0]  in_last,
    output logic [N-1:0]  in_ready,
    output logic [M-1:0]  out_data,
    output logic          out_valid,
    output logic          out_last,
    output logic [IW-1:0] out_sel,
    input  logic          out_ready
);

    arb_state_e    state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] lock_idx;
    logic [IW-1:0] grant;
    logic          any_req;
    logic [IW-1:0] sel_idx;
    logic          load_en;
    logic          ready_en;
    logic          accept;

    rr_arbiter #(.N(N)) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .grant   (grant),
        .any_req (any_req)
    );

    // Mid-packet the locked channel owns the output even through bubbles.
    always_comb begin
        load_en  = !out_valid || out_ready;
        sel_idx  = (state == LOCKED) ? lock_idx : grant;
        ready_en = rst_n && load_en && ((state == LOCKED) || any_req);
        accept   = ready_en && in_valid[sel_idx];
        in_ready = ready_en ? (N'(1) << sel_idx) : '0;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            lock_idx  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else begin
            if (load_en) begin
                out_valid <= accept;
                if (accept) begin
                    out_data <= in_data[sel_idx];
                    out_last <= in_last[sel_idx];
                    out_sel  <= sel_idx;
                end
            end
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (in_last[sel_idx]) begin
                            ptr <= IW'(rr_next(int'(sel_idx), N));
                        end else begin
                            state    <= LOCKED;
                            lock_idx <= sel_idx;
                        end
                    end
                    LOCKED: begin
                        if (in_last[sel_idx]) begin
                            state <= IDLE;
                            ptr   <= IW'(rr_next(int'(lock_idx), N));
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
